// File: rtl/half_adder.sv
// Registered, flow-controlled array of independent half-adder lanes with a
// one-deep valid/ready output register and a saturating carry counter.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic             in_hs, out_hs;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  // Any overflow into the bits above CNT_W pins the counter at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(inc);
    if (|s[SUM_W-1:CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Input stage: handshake decode and next-state of the output register
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    in_hs       = in_valid && in_ready;
    out_hs      = out_valid_q && out_ready;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    carry_cnt_d = carry_cnt_q;
    if (in_hs) begin
      out_valid_d = 1'b1;
      sum_d       = a ^ b;
      carry_d     = a & b;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (clr_cnt)     carry_cnt_d = '0;
    else if (out_hs) carry_cnt_d = sat_add(carry_cnt_q, popcount(carry_q));
  end

  // Output stage: result register and statistics counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      carry_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: a 4-lane instance and a 1-lane/2-bit-counter instance
// share control, checked against a transaction-queue model plus literal cases.
module tb_half_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid, out_ready, clr_cnt;
  logic [3:0] a_w, b_w;

  logic       in_ready_w, out_valid_w;
  logic [3:0] sum_w, carry_w;
  logic [5:0] cnt_w;

  logic       in_ready_s, out_valid_s;
  logic [0:0] sum_s, carry_s;
  logic [1:0] cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  half_adder #(.WIDTH(4), .CNT_W(6)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .sum(sum_w), .carry(carry_w), .clr_cnt(clr_cnt), .carry_cnt(cnt_w)
  );

  half_adder #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a_w[0:0]), .b(b_w[0:0]), .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .carry(carry_s), .clr_cnt(clr_cnt), .carry_cnt(cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: results waiting for the consumer, cumulative carry totals.
  typedef struct packed {
    logic [3:0] s;
    logic [3:0] c;
  } res_t;

  res_t q[$];
  res_t last_res = '0;
  int   m_cnt    = 0;
  int   m_cnt_s  = 0;

  always @(posedge clk or negedge rst_n) begin
    bit take, give;
    if (!rst_n) begin
      q.delete();
      last_res = '0;
      m_cnt    = 0;
      m_cnt_s  = 0;
    end else begin
      take = in_valid && (q.size() == 0 || out_ready);
      give = (q.size() != 0) && out_ready;
      if (give) begin
        m_cnt   = sat(m_cnt + $countones(q[0].c), 63);
        m_cnt_s = sat(m_cnt_s + int'(q[0].c[0]), 3);
        void'(q.pop_front());
      end
      if (clr_cnt) begin
        m_cnt   = 0;
        m_cnt_s = 0;
      end
      if (take) begin
        last_res = '{s: a_w ^ b_w, c: a_w & b_w};
        q.push_back(last_res);
      end
    end
  end

  always @(negedge clk) begin
    chk("w4_out_valid", 32'(out_valid_w), 32'(q.size() != 0));
    chk("w4_in_ready",  32'(in_ready_w),  32'(q.size() == 0 || out_ready));
    chk("w4_sum",       32'(sum_w),       32'(last_res.s));
    chk("w4_carry",     32'(carry_w),     32'(last_res.c));
    chk("w4_carry_cnt", 32'(cnt_w),       32'(m_cnt));
    chk("w1_out_valid", 32'(out_valid_s), 32'(q.size() != 0));
    chk("w1_in_ready",  32'(in_ready_s),  32'(q.size() == 0 || out_ready));
    chk("w1_sum",       32'(sum_s),       32'(last_res.s[0]));
    chk("w1_carry",     32'(carry_s),     32'(last_res.c[0]));
    chk("w1_carry_cnt", 32'(cnt_s),       32'(m_cnt_s));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] tt_s, tt_c, pa, pb;
    logic [1:0] sat_exp [5];
    tt_s = 4'b0110;
    tt_c = 4'b1000;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    a_w = '0; b_w = '0;
    #1;
    chk("reset_out_valid", 32'(out_valid_w), 0);
    chk("reset_in_ready",  32'(in_ready_w), 1);
    chk("reset_sum",       32'(sum_w), 0);
    chk("reset_cnt",       32'(cnt_w), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Truth table on the single-lane instance
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_w = {3'b000, i[1]};
      b_w = {3'b000, i[0]};
      step();
      chk("tt_out_valid", 32'(out_valid_s), 1);
      chk("tt_sum",   32'(sum_s),   32'(tt_s[i]));
      chk("tt_carry", 32'(carry_s), 32'(tt_c[i]));
    end
    in_valid = 1'b0;
    step();
    chk("tt_carry_cnt", 32'(cnt_s), 1);

    // Backpressure on the 4-lane instance
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("bp_cleared", 32'(cnt_w), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_w = 4'b1111;
    b_w = 4'b0101;
    step();
    for (int k = 0; k < 3; k++) begin
      a_w = 4'($urandom);
      b_w = 4'($urandom);
      chk("bp_out_valid", 32'(out_valid_w), 1);
      chk("bp_sum",       32'(sum_w), 32'hA);
      chk("bp_carry",     32'(carry_w), 32'h5);
      chk("bp_in_ready",  32'(in_ready_w), 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready_w), 1);
    step();
    chk("bp_drained",   32'(out_valid_w), 0);
    chk("bp_carry_cnt", 32'(cnt_w), 2);

    // Saturation on the 2-bit counter, then clear against a carry handshake
    clr_cnt = 1'b1;
    step();
    clr_cnt  = 1'b0;
    in_valid = 1'b1;
    a_w = 4'hF;
    b_w = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) in_valid = 1'b0;
      step();
      if (k >= 2) chk("sat_cnt", 32'(cnt_s), 32'(sat_exp[k-2]));
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    clr_cnt  = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_over_inc_w1", 32'(cnt_s), 0);
    chk("clr_over_inc_w4", 32'(cnt_w), 0);

    // Back-to-back streaming
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_w = 4'($urandom);
      b_w = 4'($urandom);
      pa = a_w;
      pb = b_w;
      step();
      chk("stream_in_ready",  32'(in_ready_w), 1);
      chk("stream_out_valid", 32'(out_valid_w), 1);
      chk("stream_sum",       32'(sum_w), 32'(pa ^ pb));
      chk("stream_carry",     32'(carry_w), 32'(pa & pb));
    end

    // Reset between edges while a result is held
    a_w = 4'hF;
    b_w = 4'hF;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid_w), 0);
    chk("rst_mid_sum",       32'(sum_w), 0);
    chk("rst_mid_carry",     32'(carry_w), 0);
    chk("rst_mid_cnt",       32'(cnt_w), 0);
    chk("rst_mid_cnt_w1",    32'(cnt_s), 0);
    chk("rst_mid_in_ready",  32'(in_ready_w), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr_cnt   = ($urandom % 50) == 0;
      a_w = 4'($urandom);
      b_w = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
